zeroriscy_md_iter_unit: RTL and testbench

//  Parametrised iterative multiply/divide unit for the EX stage, one radix-2 step per cycle.

---
 rtl/zeroriscy_md_iter_unit_if.sv | 27 ++
 rtl/zeroriscy_md_iter_unit.sv | 210 +++++++++++++++++++++
 tb/tb_zeroriscy_md_iter_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zeroriscy_md_iter_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master side (ID/EX stage) issues operations and drains results.
// The slave side is the unit itself.
interface zeroriscy_md_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       md_op_i;
  logic [1:0]       signed_mode_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             kill_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;

  modport master (
    output in_valid_i, md_op_i, signed_mode_i, op_a_i, op_b_i, kill_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o
  );

  modport slave (
    input  in_valid_i, md_op_i, signed_mode_i, op_a_i, op_b_i, kill_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o
  );
endinterface

// File: rtl/zeroriscy_md_iter_unit.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Multiplies by shift-add and divides by restoring division on operand
// magnitudes, one step per cycle, then applies sign correction in a single
// FINISH cycle. Divide-by-zero and signed overflow bypass the iteration.
module zeroriscy_md_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  zeroriscy_md_iter_unit_if.slave md
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [1:0] MD_OP_MULL = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Accept-side decode
  logic               div_signed_in;
  logic               sgn_a_in, sgn_b_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic               div_zero_in, div_ovf_in;

  // Iteration step
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH:0]     div_shift, div_diff, rem_step;
  logic               div_bit;
  logic [WIDTH-1:0]   quo_step;

  // Sign correction
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   finish_word;

  // Two's-complement negate when neg is set; MIN_INT maps onto itself.
  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? WIDTH'(-sv) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    logic signed [2*WIDTH-1:0] sv;
    sv = $signed(v);
    return neg ? (2*WIDTH)'(-sv) : v;
  endfunction

  // Operand signs, magnitudes and divide fast-path detection at the accept edge
  always_comb begin
    div_signed_in = (md.signed_mode_i == 2'b11);
    if (md.md_op_i[1]) begin
      sgn_a_in = div_signed_in & md.op_a_i[WIDTH-1];
      sgn_b_in = div_signed_in & md.op_b_i[WIDTH-1];
    end else begin
      sgn_a_in = md.signed_mode_i[0] & md.op_a_i[WIDTH-1];
      sgn_b_in = md.signed_mode_i[1] & md.op_b_i[WIDTH-1];
    end
    mag_a_in    = cond_neg_w(md.op_a_i, sgn_a_in);
    mag_b_in    = cond_neg_w(md.op_b_i, sgn_b_in);
    div_zero_in = md.md_op_i[1] & (md.op_b_i == '0);
    div_ovf_in  = md.md_op_i[1] & div_signed_in & (md.op_a_i == MIN_INT) & (md.op_b_i == '1);
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : '0)};
    prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    // Partial remainder is always below the divisor, so the shifted value is
    // below twice the divisor and the top bit of the difference is the borrow.
    // rem_q[WIDTH] acts as a carry guard and stays clear for in-range operands.
    div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_bit   = rem_q[WIDTH] | ~div_diff[WIDTH];
    rem_step  = div_bit ? div_diff : div_shift;
    quo_step  = {quo_q[WIDTH-2:0], div_bit};
  end

  // Sign correction and output word selection for the FINISH cycle
  always_comb begin
    prod_fix = cond_neg_2w(prod_q, neg_a_q ^ neg_b_q);
    case (op_q)
      MD_OP_MULL: finish_word = prod_fix[WIDTH-1:0];
      MD_OP_MULH: finish_word = prod_fix[2*WIDTH-1:WIDTH];
      MD_OP_DIV:  finish_word = cond_neg_w(quo_q, neg_a_q ^ neg_b_q);
      default:    finish_word = cond_neg_w(rem_q[WIDTH-1:0], neg_a_q);
    endcase
  end

  // Next-state and datapath update; kill overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (md.in_valid_i && !md.kill_i) begin
          op_d    = md.md_op_i;
          neg_a_d = sgn_a_in;
          neg_b_d = sgn_b_in;
          a_d     = mag_a_in;
          b_d     = mag_b_in;
          cnt_d   = CNT_INIT;
          prod_d  = {{WIDTH{1'b0}}, mag_b_in};
          rem_d   = '0;
          quo_d   = mag_a_in;
          state_d = CALC;
          // Fast paths preload final words with sign correction disabled,
          // so FINISH passes them through unchanged.
          if (div_zero_in) begin
            quo_d   = '1;
            rem_d   = {1'b0, md.op_a_i};
            neg_a_d = 1'b0;
            neg_b_d = 1'b0;
            state_d = FINISH;
          end else if (div_ovf_in) begin
            quo_d   = MIN_INT;
            rem_d   = '0;
            neg_a_d = 1'b0;
            neg_b_d = 1'b0;
            state_d = FINISH;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (op_q[1]) begin
          rem_d = rem_step;
          quo_d = quo_step;
        end else begin
          prod_d = prod_step;
        end
        if (cnt_q == CNT_ONE) state_d = FINISH;
      end
      FINISH: begin
        result_d = finish_word;
        state_d  = DONE;
      end
      DONE: begin
        if (md.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (md.kill_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // State, counter and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
    end
  end

  assign md.in_ready_o  = (state_q == IDLE);
  assign md.out_valid_o = (state_q == DONE);
  assign md.result_o    = result_q;

endmodule

// File: tb/tb_zeroriscy_md_iter_unit.sv
// Self-checking bench for zeroriscy_md_iter_unit: directed cases, handshake
// corner cases, kill/reset behaviour and randomized ops against an
// arithmetic reference model. A WIDTH=8 instance covers the narrow case.
module tb_zeroriscy_md_iter_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  zeroriscy_md_iter_unit_if #(.WIDTH(32)) ifc ();
  zeroriscy_md_iter_unit_if #(.WIDTH(8))  ifc8 ();

  zeroriscy_md_iter_unit #(.WIDTH(32)) dut  (.clk(clk), .rst_n(rst_n), .md(ifc.slave));
  zeroriscy_md_iter_unit #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .md(ifc8.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic following RISC-V M semantics.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [1:0] mode,
                                        input logic [31:0] a, input logic [31:0] b);
    longint     ea, eb;
    logic [63:0] p;
    int          sq, sr;
    if (!op[1]) begin
      ea = mode[0] ? longint'($signed(a)) : longint'({32'd0, a});
      eb = mode[1] ? longint'($signed(b)) : longint'({32'd0, b});
      p  = 64'(ea * eb);
      return op[0] ? p[63:32] : p[31:0];
    end
    if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
    if (mode == 2'b11) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'd0 : 32'h8000_0000;
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      return op[0] ? 32'(sr) : 32'(sq);
    end
    return op[0] ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [1:0] mode,
                                   input logic [31:0] a, input logic [31:0] b);
    if (op[1] && (b == 32'd0 || (mode == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
    return 34;
  endfunction

  // Issue one op, scramble inputs after accept, wait for the result, drain it.
  // lat counts edges from the accepting edge (inclusive) to out_valid_o.
  task automatic run32(input logic [1:0] op, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    ifc.md_op_i = op; ifc.signed_mode_i = mode;
    ifc.op_a_i = a; ifc.op_b_i = b; ifc.in_valid_i = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid_i = 1'b0;
    ifc.md_op_i = 2'($urandom); ifc.signed_mode_i = 2'($urandom);
    ifc.op_a_i = $urandom; ifc.op_b_i = $urandom;
    lat = 1;
    while (ifc.out_valid_o !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = ifc.result_o;
    @(negedge clk); ifc.out_ready_i = 1'b1;
    @(posedge clk); #1; ifc.out_ready_i = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [1:0] op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int          lat;
    run32(op, mode, a, b, res, lat);
    chk({tag, "_res"}, 64'(res), 64'(exp_res));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, r0, prev, a, b;
    logic [1:0]  op, mode;
    int          lat, vcount, sel;

    ifc.in_valid_i = 0; ifc.md_op_i = 0; ifc.signed_mode_i = 0; ifc.op_a_i = 0;
    ifc.op_b_i = 0; ifc.kill_i = 0; ifc.out_ready_i = 0;
    ifc8.in_valid_i = 0; ifc8.md_op_i = 0; ifc8.signed_mode_i = 0; ifc8.op_a_i = 0;
    ifc8.op_b_i = 0; ifc8.kill_i = 0; ifc8.out_ready_i = 0;
    rst_n = 1'b0;
    #23;
    chk("rst_in_ready",  64'(ifc.in_ready_o),  64'(1));
    chk("rst_out_valid", 64'(ifc.out_valid_o), 64'(0));
    chk("rst_result",    64'(ifc.result_o),    64'(0));
    chk("rst8_in_ready", 64'(ifc8.in_ready_o), 64'(1));
    chk("rst8_result",   64'(ifc8.result_o),   64'(0));
    @(negedge clk); rst_n = 1'b1;

    // Multiply
    directed("mull_7x-3",   2'b00, 2'b11, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    directed("mulh_7x-3",   2'b01, 2'b11, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    directed("mulhu_ff",    2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    directed("mulh_ff",     2'b01, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    directed("mulhsu_m1x2", 2'b01, 2'b01, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);

    // Divide
    directed("div_-7/2",  2'b10, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    directed("rem_-7/2",  2'b11, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    directed("divu_7/2",  2'b10, 2'b00, 32'd7, 32'd2, 32'd3, 34);
    directed("remu_7/2",  2'b11, 2'b00, 32'd7, 32'd2, 32'd1, 34);
    directed("div_mode01_unsigned", 2'b10, 2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);

    // Fast paths
    directed("div_x/0",   2'b10, 2'b11, 32'h0000_0055, 32'd0, 32'hFFFF_FFFF, 2);
    directed("rem_x/0",   2'b11, 2'b00, 32'h0000_1234, 32'd0, 32'h0000_1234, 2);
    directed("rem_neg/0", 2'b11, 2'b11, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 2);
    directed("div_ovf",   2'b10, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    directed("rem_ovf",   2'b11, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

    // Kill at CALC step 10
    prev = ifc.result_o;
    @(negedge clk);
    ifc.md_op_i = 2'b10; ifc.signed_mode_i = 2'b00;
    ifc.op_a_i = 32'd12345; ifc.op_b_i = 32'd77; ifc.in_valid_i = 1'b1;
    @(posedge clk); #1; ifc.in_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); ifc.kill_i = 1'b1;
    @(posedge clk); #1; ifc.kill_i = 1'b0;
    chk("kill_in_ready",  64'(ifc.in_ready_o),  64'(1));
    chk("kill_out_valid", 64'(ifc.out_valid_o), 64'(0));
    vcount = 0;
    repeat (40) begin @(posedge clk); #1; if (ifc.out_valid_o) vcount++; end
    chk("kill_no_valid", 64'(vcount), 64'(0));
    chk("kill_result_hold", 64'(ifc.result_o), 64'(prev));
    directed("div_100/7", 2'b10, 2'b00, 32'd100, 32'd7, 32'd14, 34);

    // Hold in DONE with out_ready low and a competing request
    @(negedge clk);
    ifc.md_op_i = 2'b00; ifc.signed_mode_i = 2'b00;
    ifc.op_a_i = 32'd1234; ifc.op_b_i = 32'd5678; ifc.in_valid_i = 1'b1;
    @(posedge clk); #1; ifc.in_valid_i = 1'b0;
    lat = 1;
    while (ifc.out_valid_o !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("hold_lat", 64'(lat), 64'(34));
    r0 = ifc.result_o;
    chk("hold_res", 64'(r0), 64'(32'd7006652));
    @(negedge clk);
    ifc.md_op_i = 2'b10; ifc.signed_mode_i = 2'b00;
    ifc.op_a_i = 32'd1000; ifc.op_b_i = 32'd7; ifc.in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_stable",    64'(ifc.result_o),    64'(r0));
      chk("hold_in_ready",  64'(ifc.in_ready_o),  64'(0));
      chk("hold_out_valid", 64'(ifc.out_valid_o), 64'(1));
    end
    @(negedge clk); ifc.out_ready_i = 1'b1;
    @(posedge clk); #1; ifc.out_ready_i = 1'b0;
    chk("drain_out_valid", 64'(ifc.out_valid_o), 64'(0));
    chk("drain_no_accept", 64'(ifc.in_ready_o),  64'(1));
    @(posedge clk); #1;
    chk("next_accept", 64'(ifc.in_ready_o), 64'(0));
    ifc.in_valid_i = 1'b0; ifc.op_a_i = $urandom;
    lat = 1;
    while (ifc.out_valid_o !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("after_drain_lat", 64'(lat), 64'(34));
    chk("after_drain_res", 64'(ifc.result_o), 64'(32'd142));
    prev = ifc.result_o;

    // Kill while DONE
    @(negedge clk); ifc.kill_i = 1'b1;
    @(posedge clk); #1; ifc.kill_i = 1'b0;
    chk("killdone_out_valid", 64'(ifc.out_valid_o), 64'(0));
    chk("killdone_in_ready",  64'(ifc.in_ready_o),  64'(1));
    chk("killdone_hold",      64'(ifc.result_o),    64'(prev));

    // Kill in IDLE blocks accept
    @(negedge clk);
    ifc.md_op_i = 2'b00; ifc.op_a_i = 32'd3; ifc.op_b_i = 32'd3;
    ifc.in_valid_i = 1'b1; ifc.kill_i = 1'b1;
    @(posedge clk); #1; ifc.in_valid_i = 1'b0; ifc.kill_i = 1'b0;
    chk("kill_idle_block", 64'(ifc.in_ready_o), 64'(1));

    // Asynchronous reset mid-operation
    @(negedge clk);
    ifc.md_op_i = 2'b01; ifc.signed_mode_i = 2'b11;
    ifc.op_a_i = 32'h1234_5678; ifc.op_b_i = 32'h9ABC_DEF0; ifc.in_valid_i = 1'b1;
    @(posedge clk); #1; ifc.in_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  64'(ifc.in_ready_o),  64'(1));
    chk("arst_out_valid", 64'(ifc.out_valid_o), 64'(0));
    chk("arst_result",    64'(ifc.result_o),    64'(0));
    @(negedge clk); rst_n = 1'b1;
    vcount = 0;
    repeat (40) begin @(posedge clk); #1; if (ifc.out_valid_o) vcount++; end
    chk("arst_no_valid", 64'(vcount), 64'(0));

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      op   = 2'($urandom_range(0, 3));
      mode = 2'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      sel  = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'd1;
      else if (sel == 3) b = $urandom_range(1, 20);
      run32(op, mode, a, b, res, lat);
      chk($sformatf("rnd%0d_op%0d_m%0d_a%0h_b%0h_res", n, op, mode, a, b),
          64'(res), 64'(model(op, mode, a, b)));
      chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(model_lat(op, mode, a, b)));
    end

    // WIDTH=8 instance: MULH 0x80*0x80 signed
    @(negedge clk);
    ifc8.md_op_i = 2'b01; ifc8.signed_mode_i = 2'b11;
    ifc8.op_a_i = 8'h80; ifc8.op_b_i = 8'h80; ifc8.in_valid_i = 1'b1;
    @(posedge clk); #1; ifc8.in_valid_i = 1'b0; ifc8.op_a_i = 8'h11;
    lat = 1;
    while (ifc8.out_valid_o !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("w8_mulh_res", 64'(ifc8.result_o), 64'(8'h40));
    chk("w8_mulh_lat", 64'(lat), 64'(10));
    @(negedge clk); ifc8.out_ready_i = 1'b1;
    @(posedge clk); #1; ifc8.out_ready_i = 1'b0;
    chk("w8_drain", 64'(ifc8.out_valid_o), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
